// File: rtl/ysyx_25070198_bus_pkg.sv
// Shared types and constants for the IFU/LSU memory bus arbiter.
// Optional feature macro in the top: YSYX_25070198_ARB_PERF_EN.
package ysyx_25070198_bus_pkg;

  localparam int AW_DEFAULT   = 32;
  localparam int DW_DEFAULT   = 32;
  localparam int MASK_W       = DW_DEFAULT / 8;
  localparam int PERF_CNT_W   = 32;

  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IFU_BUSY = 2'd1,
    LSU_BUSY = 2'd2
  } arb_state_t;

  // On a tie the master that did not win last time gets the bus.
  function automatic logic pick_master(input logic ifuReq,
                                       input logic lsuReq,
                                       input logic lastGrant);
    if (ifuReq && lsuReq) begin
      return ~lastGrant;
    end else if (lsuReq) begin
      return MST_LSU;
    end else begin
      return MST_IFU;
    end
  endfunction

endpackage

// File: rtl/ysyx_25070198_arb_perf.sv
// Grant and contention counters for the bus arbiter; all counters wrap modulo 2^32.
// Instantiated by the top only when YSYX_25070198_ARB_PERF_EN is defined.
module ysyx_25070198_arb_perf
  import ysyx_25070198_bus_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifuGrant_i,
  input  logic                  lsuGrant_i,
  input  logic                  conflict_i,
  output logic [PERF_CNT_W-1:0] perfIfuCnt_o,
  output logic [PERF_CNT_W-1:0] perfLsuCnt_o,
  output logic [PERF_CNT_W-1:0] perfConfCnt_o
);

  logic [PERF_CNT_W-1:0] ifuCnt_q, ifuCnt_d;
  logic [PERF_CNT_W-1:0] lsuCnt_q, lsuCnt_d;
  logic [PERF_CNT_W-1:0] confCnt_q, confCnt_d;

  always_comb begin
    ifuCnt_d  = ifuCnt_q;
    lsuCnt_d  = lsuCnt_q;
    confCnt_d = confCnt_q;
    if (ifuGrant_i) ifuCnt_d = ifuCnt_q + 1'b1;
    if (lsuGrant_i) lsuCnt_d = lsuCnt_q + 1'b1;
    if (conflict_i) confCnt_d = confCnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifuCnt_q  <= '0;
      lsuCnt_q  <= '0;
      confCnt_q <= '0;
    end else begin
      ifuCnt_q  <= ifuCnt_d;
      lsuCnt_q  <= lsuCnt_d;
      confCnt_q <= confCnt_d;
    end
  end

  assign perfIfuCnt_o  = ifuCnt_q;
  assign perfLsuCnt_o  = lsuCnt_q;
  assign perfConfCnt_o = confCnt_q;

endmodule

// File: rtl/ysyx_25070198_bus_arbiter.sv
// Round-robin arbiter merging the IFU fetch port and LSU data port onto one memory port.
// Define YSYX_25070198_ARB_PERF_EN to enable the grant/contention performance counters.
module ysyx_25070198_bus_arbiter
  import ysyx_25070198_bus_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  ifu_reqValid,
  input  logic [AW-1:0]         ifu_raddr,
  output logic                  ifu_respValid,
  output logic [DW-1:0]         ifu_rdata,

  input  logic                  lsu_reqValid,
  input  logic [AW-1:0]         lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DW-1:0]         lsu_wdata,
  input  logic [DW/8-1:0]       lsu_wmask,
  output logic                  lsu_respValid,
  output logic [DW-1:0]         lsu_rdata,

  output logic                  mem_reqValid,
  output logic [AW-1:0]         mem_addr,
  output logic                  mem_wen,
  output logic [DW-1:0]         mem_wdata,
  output logic [DW/8-1:0]       mem_wmask,
  input  logic                  mem_respValid,
  input  logic [DW-1:0]         mem_rdata,

  output logic [PERF_CNT_W-1:0] perf_ifu_cnt,
  output logic [PERF_CNT_W-1:0] perf_lsu_cnt,
  output logic [PERF_CNT_W-1:0] perf_conf_cnt
);

  localparam int MW = DW / 8;

  arb_state_t    state_q, state_d;
  logic          lastGrant_q, lastGrant_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wen_q, wen_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [MW-1:0] wmask_q, wmask_d;

  logic          grantValid;
  logic          grantMst;

  // A grant can only be taken from IDLE, which keeps one access outstanding at most.
  always_comb begin
    grantValid = (state_q == IDLE) && (ifu_reqValid || lsu_reqValid);
    grantMst   = pick_master(ifu_reqValid, lsu_reqValid, lastGrant_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grantValid) begin
          state_d = (grantMst == MST_LSU) ? LSU_BUSY : IFU_BUSY;
        end
      end
      IFU_BUSY, LSU_BUSY: begin
        if (mem_respValid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The payload is frozen at grant so the memory side never follows the masters' inputs.
  always_comb begin
    lastGrant_d = lastGrant_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    if (grantValid) begin
      lastGrant_d = grantMst;
      if (grantMst == MST_LSU) begin
        addr_d  = lsu_addr;
        wen_d   = lsu_wen;
        wdata_d = lsu_wdata;
        wmask_d = lsu_wmask;
      end else begin
        addr_d  = ifu_raddr;
        wen_d   = 1'b0;
        wdata_d = '0;
        wmask_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastGrant_q <= MST_IFU;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
    end else begin
      lastGrant_q <= lastGrant_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
    end
  end

  // Responses are steered by state only, so a stray response in IDLE reaches nobody.
  always_comb begin
    mem_reqValid  = (state_q != IDLE);
    ifu_respValid = (state_q == IFU_BUSY) && mem_respValid;
    lsu_respValid = (state_q == LSU_BUSY) && mem_respValid;
    ifu_rdata     = ifu_respValid ? mem_rdata : '0;
    lsu_rdata     = lsu_respValid ? mem_rdata : '0;
  end

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

`ifdef YSYX_25070198_ARB_PERF_EN
  logic ifuGrant;
  logic lsuGrant;
  logic conflict;

  // With both requesting, at most one of them can ever be in service.
  assign ifuGrant = grantValid && (grantMst == MST_IFU);
  assign lsuGrant = grantValid && (grantMst == MST_LSU);
  assign conflict = ifu_reqValid && lsu_reqValid;

  ysyx_25070198_arb_perf u_perf (
    .clk          (clk),
    .rst          (rst),
    .ifuGrant_i   (ifuGrant),
    .lsuGrant_i   (lsuGrant),
    .conflict_i   (conflict),
    .perfIfuCnt_o (perf_ifu_cnt),
    .perfLsuCnt_o (perf_lsu_cnt),
    .perfConfCnt_o(perf_conf_cnt)
  );
`else
  assign perf_ifu_cnt  = '0;
  assign perf_lsu_cnt  = '0;
  assign perf_conf_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_25070198_bus_arbiter.sv
// Scoreboard bench for the IFU/LSU bus arbiter; expected grants are queued as requests are driven.
// Perf counter expectations follow YSYX_25070198_ARB_PERF_EN.
module tb_ysyx_25070198_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_reqValid;
  logic [AW-1:0] ifu_raddr;
  logic          ifu_respValid;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_reqValid;
  logic [AW-1:0] lsu_addr;
  logic          lsu_wen;
  logic [DW-1:0] lsu_wdata;
  logic [MW-1:0] lsu_wmask;
  logic          lsu_respValid;
  logic [DW-1:0] lsu_rdata;
  logic          mem_reqValid;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic          mem_respValid;
  logic [DW-1:0] mem_rdata;
  logic [31:0]   perf_ifu_cnt;
  logic [31:0]   perf_lsu_cnt;
  logic [31:0]   perf_conf_cnt;

  ysyx_25070198_bus_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_reqValid (ifu_reqValid),
    .ifu_raddr    (ifu_raddr),
    .ifu_respValid(ifu_respValid),
    .ifu_rdata    (ifu_rdata),
    .lsu_reqValid (lsu_reqValid),
    .lsu_addr     (lsu_addr),
    .lsu_wen      (lsu_wen),
    .lsu_wdata    (lsu_wdata),
    .lsu_wmask    (lsu_wmask),
    .lsu_respValid(lsu_respValid),
    .lsu_rdata    (lsu_rdata),
    .mem_reqValid (mem_reqValid),
    .mem_addr     (mem_addr),
    .mem_wen      (mem_wen),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_respValid(mem_respValid),
    .mem_rdata    (mem_rdata),
    .perf_ifu_cnt (perf_ifu_cnt),
    .perf_lsu_cnt (perf_lsu_cnt),
    .perf_conf_cnt(perf_conf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          isLsu;
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t expQ[$];

  int testsRun    = 0;
  int testsFailed = 0;
  int cycle       = 0;
  int confExp     = 0;
  int ifuGrantExp = 0;
  int lsuGrantExp = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Reference contention count: every sampled cycle with both masters requesting.
  always @(posedge clk) begin
    if (!rst) confExp <= 0;
    else if (ifu_reqValid && lsu_reqValid) confExp <= confExp + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst           = 1'b0;
    ifu_reqValid  = 1'b0;
    ifu_raddr     = '0;
    lsu_reqValid  = 1'b0;
    lsu_addr      = '0;
    lsu_wen       = 1'b0;
    lsu_wdata     = '0;
    lsu_wmask     = '0;
    mem_respValid = 1'b0;
    mem_rdata     = '0;
    expQ.delete();
    ifuGrantExp   = 0;
    lsuGrantExp   = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic applyStimulus(input logic isLsu, input logic [AW-1:0] addr,
                               input logic wen, input logic [DW-1:0] wdata,
                               input logic [MW-1:0] wmask, input logic [DW-1:0] rdata);
    exp_t e;
    e.isLsu = isLsu;
    e.addr  = addr;
    e.wen   = isLsu ? wen : 1'b0;
    e.wdata = wdata;
    e.wmask = isLsu ? wmask : '0;
    e.rdata = rdata;
    if (isLsu) begin
      lsu_reqValid = 1'b1;
      lsu_addr     = addr;
      lsu_wen      = wen;
      lsu_wdata    = wdata;
      lsu_wmask    = wmask;
    end else begin
      ifu_reqValid = 1'b1;
      ifu_raddr    = addr;
    end
    expQ.push_back(e);
  endtask

  task automatic waitReq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_reqValid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Memory model: answers `delay` cycles after the request appears, then checks routing.
  task automatic serve(input int delay, output int reqCycle, output int respCycle);
    exp_t e;
    bit   ok;
    reqCycle  = 0;
    respCycle = 0;
    waitReq(ok);
    checkOutput("reqSeen", ok, 1);
    if (!ok) return;
    reqCycle = cycle;
    checkOutput("queueNotEmpty", expQ.size() > 0, 1);
    if (expQ.size() == 0) return;
    e = expQ.pop_front();
    if (e.isLsu) lsuGrantExp++;
    else ifuGrantExp++;
    checkOutput(e.isLsu ? "lsuMemAddr" : "ifuMemAddr", mem_addr, e.addr);
    checkOutput(e.isLsu ? "lsuMemWen" : "ifuMemWen", mem_wen, e.wen);
    checkOutput(e.isLsu ? "lsuMemWmask" : "ifuMemWmask", mem_wmask, e.wmask);
    if (e.isLsu) checkOutput("lsuMemWdata", mem_wdata, e.wdata);
    checkOutput("noEarlyResp", {ifu_respValid, lsu_respValid}, 2'b00);
    repeat (delay) @(posedge clk);
    #1;
    mem_respValid = 1'b1;
    mem_rdata     = e.rdata;
    @(negedge clk);
    respCycle = cycle;
    checkOutput("ifuRespValid", ifu_respValid, !e.isLsu);
    checkOutput("lsuRespValid", lsu_respValid, e.isLsu);
    checkOutput("ifuRdata", ifu_rdata, e.isLsu ? '0 : e.rdata);
    checkOutput("lsuRdata", lsu_rdata, e.isLsu ? e.rdata : '0);
    @(posedge clk);
    #1;
    mem_respValid = 1'b0;
    mem_rdata     = '0;
    if (e.isLsu) lsu_reqValid = 1'b0;
    else ifu_reqValid = 1'b0;
    @(negedge clk);
    checkOutput("respIsPulse", {ifu_respValid, lsu_respValid}, 2'b00);
    checkOutput("bubbleIdle", mem_reqValid, 0);
  endtask

  task automatic checkPerf(input string tag);
`ifdef YSYX_25070198_ARB_PERF_EN
    checkOutput({tag, "PerfIfu"}, perf_ifu_cnt, ifuGrantExp);
    checkOutput({tag, "PerfLsu"}, perf_lsu_cnt, lsuGrantExp);
    checkOutput({tag, "PerfConf"}, perf_conf_cnt, confExp);
`else
    checkOutput({tag, "PerfIfu"}, perf_ifu_cnt, 0);
    checkOutput({tag, "PerfLsu"}, perf_lsu_cnt, 0);
    checkOutput({tag, "PerfConf"}, perf_conf_cnt, 0);
`endif
  endtask

  initial begin
    int rq1, rs1, rq2, rs2;
    bit ok;

    doReset();
    @(negedge clk);
    checkOutput("rstReqValid", mem_reqValid, 0);
    checkOutput("rstAddr", mem_addr, 0);
    checkOutput("rstWen", mem_wen, 0);
    checkOutput("rstWdata", mem_wdata, 0);
    checkOutput("rstWmask", mem_wmask, 0);
    checkOutput("rstResp", {ifu_respValid, lsu_respValid}, 2'b00);
    checkPerf("rst");

    // Lone IFU read, then a lone LSU write.
    applyStimulus(1'b0, 32'h8000_0000, 1'b0, '0, '0, 32'h0010_0073);
    serve(3, rq1, rs1);
    applyStimulus(1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0);
    serve(2, rq1, rs1);

    // Back-to-back IFU fetches: one IDLE bubble between response and next request.
    applyStimulus(1'b0, 32'h8000_0004, 1'b0, '0, '0, 32'h1234_5678);
    serve(1, rq1, rs1);
    applyStimulus(1'b0, 32'h8000_0008, 1'b0, '0, '0, 32'hAABB_CCDD);
    serve(2, rq2, rs2);
    checkOutput("bubbleLatency", rq2 - rs1, 2);

    // LSU read with a partial mask.
    applyStimulus(1'b1, 32'h8000_2000, 1'b0, 32'h0, 4'h3, 32'hCAFE_F00D);
    serve(1, rq1, rs1);

    // Ties after reset: LSU wins first; re-raising the winner each time forces alternation.
    doReset();
    applyStimulus(1'b1, 32'h8000_3000, 1'b1, 32'h1111_1111, 4'h1, 32'h0);
    applyStimulus(1'b0, 32'h8000_0100, 1'b0, '0, '0, 32'h2222_2222);
    serve(2, rq1, rs1);
    applyStimulus(1'b1, 32'h8000_3004, 1'b0, 32'h0, 4'hF, 32'h3333_3333);
    serve(2, rq1, rs1);
    applyStimulus(1'b0, 32'h8000_0104, 1'b0, '0, '0, 32'h4444_4444);
    serve(1, rq1, rs1);
    serve(1, rq1, rs1);
    repeat (2) @(negedge clk);
    checkPerf("tie");

    // Reset while LSU is in flight, followed by a late response.
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 32'h8000_4000, 1'b1, 32'h5A5A_5A5A, 4'hC, 32'h0);
    waitReq(ok);
    checkOutput("midRstReqSeen", ok, 1);
    #2;
    rst          = 1'b0;
    lsu_reqValid = 1'b0;
    expQ.delete();
    #1;
    checkOutput("asyncRstReqValid", mem_reqValid, 0);
    checkOutput("asyncRstAddr", mem_addr, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    mem_respValid = 1'b1;
    mem_rdata     = 32'h7777_7777;
    @(negedge clk);
    checkOutput("lateRespDropped", {ifu_respValid, lsu_respValid}, 2'b00);
    checkOutput("lateRespLsuRdata", lsu_rdata, 0);
    @(posedge clk);
    #1;
    mem_respValid = 1'b0;
    mem_rdata     = '0;

    // Stray response while IDLE.
    @(posedge clk);
    #1;
    mem_respValid = 1'b1;
    mem_rdata     = 32'h5555_AAAA;
    @(negedge clk);
    checkOutput("strayResp", {ifu_respValid, lsu_respValid}, 2'b00);
    checkOutput("strayIfuRdata", ifu_rdata, 0);
    checkOutput("strayLsuRdata", lsu_rdata, 0);
    @(posedge clk);
    #1;
    mem_respValid = 1'b0;
    mem_rdata     = '0;
    @(negedge clk);
    checkOutput("strayStaysIdle", mem_reqValid, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
